// File: rtl/top.sv
// Coin-operated vending controller. Tracks the inserted balance in Rs.5
// units as a six-state FSM and issues registered one-cycle pulses for
// product dispense (PA/PB/PC) and money return (change).
module top (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic [1:0] coin,
    input  logic       cancel,
    output logic       PA,
    output logic       PB,
    output logic       PC,
    output logic       change
);

    typedef enum logic [2:0] {
        S0  = 3'd0,
        S5  = 3'd1,
        S10 = 3'd2,
        S15 = 3'd3,
        S20 = 3'd4,
        S25 = 3'd5
    } state_t;

    state_t state, state_nxt;
    logic   pa_nxt, pb_nxt, pc_nxt, change_nxt;
    logic [3:0] total_units;
    logic [3:0] price_units;

    // Coin value in Rs.5 units; the invalid code 11 is worth nothing.
    function automatic logic [3:0] coin_units(input logic [1:0] c);
        case (c)
            2'b01:   coin_units = 4'd1;
            2'b10:   coin_units = 4'd2;
            default: coin_units = 4'd0;
        endcase
    endfunction

    // Product price in Rs.5 units (only meaningful when s != 11).
    function automatic logic [3:0] price_of(input logic [1:0] s);
        case (s)
            2'b00:   price_of = 4'd1;
            2'b01:   price_of = 4'd2;
            default: price_of = 4'd4;
        endcase
    endfunction

    // Balance held by a state, in Rs.5 units.
    function automatic logic [3:0] state_units(input state_t st);
        case (st)
            S5:      state_units = 4'd1;
            S10:     state_units = 4'd2;
            S15:     state_units = 4'd3;
            S20:     state_units = 4'd4;
            S25:     state_units = 4'd5;
            default: state_units = 4'd0;
        endcase
    endfunction

    // Inverse of state_units for the legal balances 0..5 units.
    function automatic state_t units_state(input logic [3:0] u);
        case (u)
            4'd1:    units_state = S5;
            4'd2:    units_state = S10;
            4'd3:    units_state = S15;
            4'd4:    units_state = S20;
            4'd5:    units_state = S25;
            default: units_state = S0;
        endcase
    endfunction

    // State register and registered output pulses; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S0;
            PA     <= 1'b0;
            PB     <= 1'b0;
            PC     <= 1'b0;
            change <= 1'b0;
        end else begin
            state  <= state_nxt;
            PA     <= pa_nxt;
            PB     <= pb_nxt;
            PC     <= pc_nxt;
            change <= change_nxt;
        end
    end

    // Next-state and next-output decision: cancel, then purchase, then
    // accumulate, and finally reject a coin that would overflow Rs.25.
    always_comb begin
        state_nxt   = state;
        pa_nxt      = 1'b0;
        pb_nxt      = 1'b0;
        pc_nxt      = 1'b0;
        change_nxt  = 1'b0;
        total_units = state_units(state) + coin_units(coin);
        price_units = price_of(sel);

        if (cancel) begin
            state_nxt  = S0;
            change_nxt = (total_units != 4'd0);
        end else if (sel != 2'b11 && total_units >= price_units) begin
            state_nxt  = S0;
            pa_nxt     = (sel == 2'b00);
            pb_nxt     = (sel == 2'b01);
            pc_nxt     = (sel == 2'b10);
            change_nxt = (total_units > price_units);
        end else if (total_units <= 4'd5) begin
            state_nxt = units_state(total_units);
        end else begin
            change_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_top.sv
// Testbench for the vending controller: directed scenarios plus a random
// run, all compared against a rupee-level behavioural model.
module tb_top;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] sel = 2'b11;
    logic [1:0] coin = 2'b00;
    logic       cancel = 1'b0;
    logic       PA, PB, PC, change;

    int checks = 0;
    int errors = 0;
    int bal = 0;          // model balance in rupees
    logic [3:0] exp;      // expected {PA,PB,PC,change}

    top dut (
        .clk(clk), .rst(rst), .sel(sel), .coin(coin), .cancel(cancel),
        .PA(PA), .PB(PB), .PC(PC), .change(change)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Drive one cycle of stimulus, advance the model, and land 1ns after the edge.
    task automatic apply(input logic [1:0] s, input logic [1:0] c, input logic k, input logic r);
        int total;
        int price;
        sel = s; coin = c; cancel = k; rst = r;
        exp = 4'b0000;
        if (r) begin
            bal = 0;
        end else begin
            total = bal + ((c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0);
            price = (s == 2'b00) ? 5 : (s == 2'b01) ? 10 : 20;
            if (k) begin
                exp[0] = (total > 0);
                bal = 0;
            end else if (s != 2'b11 && total >= price) begin
                exp[3 - int'(s)] = 1'b1;
                exp[0] = (total > price);
                bal = 0;
            end else if (total <= 25) begin
                bal = total;
            end else begin
                exp[0] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(2'b00, 2'b10, 1'b1, 1'b1);
        apply(2'b01, 2'b01, 1'b0, 1'b1);
        checks++;
        if ({PA, PB, PC, change} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {PA, PB, PC, change});
        end
        // First coin after reset release is accepted immediately.
        apply(2'b00, 2'b01, 1'b0, 1'b0);
        checks++;
        if ({PA, PB, PC, change} !== exp) begin
            errors++;
            $display("FAIL reset_first_coin got %b want %b", {PA, PB, PC, change}, exp);
        end
        apply(2'b11, 2'b00, 1'b0, 1'b0);
        checks++;
        if ({PA, PB, PC, change} !== exp) begin
            errors++;
            $display("FAIL reset_pulse_end got %b want %b", {PA, PB, PC, change}, exp);
        end
    endtask

    task automatic test_buy_a_b();
        logic [1:0] s_t [5] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
        logic [1:0] c_t [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b00};
        for (int i = 0; i < 5; i++) begin
            apply(s_t[i], c_t[i], 1'b0, 1'b0);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL buy_ab step%0d got %b want %b", i, {PA, PB, PC, change}, exp);
            end
        end
    endtask

    task automatic test_buy_c_change();
        logic [1:0] c_t [4] = '{2'b10, 2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            apply(2'b10, c_t[i], 1'b0, 1'b0);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL buy_c step%0d got %b want %b", i, {PA, PB, PC, change}, exp);
            end
        end
    endtask

    task automatic test_cancel();
        // coin, cancel pairs: insert Rs.10, cancel with refund, cancel empty,
        // cancel together with a coin, coin 11 then cancel (balance stays 0).
        logic [1:0] c_t [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00};
        logic       k_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            apply(2'b11, c_t[i], k_t[i], 1'b0);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL cancel step%0d got %b want %b", i, {PA, PB, PC, change}, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic [1:0] s_t [7] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11};
        logic [1:0] c_t [7] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
        for (int i = 0; i < 7; i++) begin
            apply(s_t[i], c_t[i], 1'b0, 1'b0);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL overflow step%0d got %b want %b", i, {PA, PB, PC, change}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Build Rs.15, reset with a purchase-worthy coin, then probe the balance.
        logic [1:0] s_t [7] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b11};
        logic [1:0] c_t [7] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b00};
        logic       r_t [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       k_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            apply(s_t[i], c_t[i], k_t[i], r_t[i]);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL reset_mid step%0d got %b want %b", i, {PA, PB, PC, change}, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] s;
        logic [1:0] c;
        logic       k;
        logic       r;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 9) < 6) ? 2'b11 : 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            k = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 49) == 0);
            apply(s, c, k, r);
            checks++;
            if ({PA, PB, PC, change} !== exp) begin
                errors++;
                $display("FAIL random cyc%0d sel=%b coin=%b cancel=%b rst=%b got %b want %b",
                         i, s, c, k, r, {PA, PB, PC, change}, exp);
            end
            checks++;
            if (!$onehot0({PA, PB, PC}) || (k && !r && (PA || PB || PC))) begin
                errors++;
                $display("FAIL random_exclusive cyc%0d got %b want at most one product, none on cancel",
                         i, {PA, PB, PC});
            end
        end
    endtask

    initial begin
        test_reset();
        test_buy_a_b();
        test_buy_c_change();
        test_cancel();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
